// File: rtl/logic_unit_pkg.sv
// Shared types for the bitwise logic unit: opcode and FSM state encodings.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NOT_A = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_PASS  = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit_alu.sv
// Bitwise function f(x, y, op) over WIDTH bits; x is operand A, y is B or the running accumulator.
// Latency: purely combinational, zero cycles.
// Backpressure: none, the caller owns all flow control.
module logic_unit_alu
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] f
);

    // Select the bitwise operation; every 3-bit code is defined.
    always_comb begin
        f = '0;
        case (op)
            OP_AND:   f = x & y;
            OP_OR:    f = x | y;
            OP_NOT_A: f = ~x;
            OP_NAND:  f = ~(x & y);
            OP_NOR:   f = ~(x | y);
            OP_XOR:   f = x ^ y;
            OP_XNOR:  f = ~(x ^ y);
            OP_PASS:  f = x;
            default:  f = x;
        endcase
    end

endmodule

// File: rtl/logic_unit.sv
// Registered bitwise logic unit with burst accumulate mode; LOGIC_UNIT_PARITY_EN adds out_parity.
// Latency: one cycle from accepting a result-producing beat to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; result held stable while stalled.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_f;
    logic [2:0]       op_sel;
    logic             accept;
    logic             result_fire;

    logic_unit_alu #(.WIDTH(WIDTH)) u_alu (
        .x  (in_a),
        .y  (alu_y),
        .op (op_sel),
        .f  (alu_f)
    );

    // FSM state register; reset discards any partial burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: a non-last accumulate beat opens a burst, a last beat closes it.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: if (in_acc && !in_last) state_d = ST_ACC;
                ST_ACC:  if (in_last)            state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake and operand steering; inside a burst B and opcode come from internal state.
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        alu_y    = in_b;
        op_sel   = in_op;
        cnt_d    = CNT_W'(1);
        if (state_q == ST_ACC) begin
            alu_y  = acc_q;
            op_sel = op_q;
            cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (state_q == ST_ACC) result_fire = accept && in_last;
        else                   result_fire = accept && (!in_acc || in_last);
    end

    // Accumulator, beat counter and latched opcode advance on every accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            op_q  <= '0;
        end else if (accept) begin
            acc_q <= alu_f;
            cnt_q <= cnt_d;
            if (state_q == ST_IDLE) op_q <= in_op;
        end
    end

    // Output register: load on a new result, otherwise drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b1;
            out_count  <= '0;
`ifdef LOGIC_UNIT_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (result_fire) begin
            out_valid  <= 1'b1;
            out_data   <= alu_f;
            out_zero   <= (alu_f == '0);
            out_count  <= cnt_d;
`ifdef LOGIC_UNIT_PARITY_EN
            out_parity <= ^alu_f;
`endif
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/logic_unit.md
# logic_unit

Parametrised, registered bitwise logic unit: the multi-bit, opcode-selected, flow-controlled successor of the single-bit two-input gate block. It applies one of eight bitwise operations to WIDTH-bit operands and adds an accumulate mode that folds a burst of operands into one result. Input and output each use a valid/ready handshake, so the block drops into any streaming datapath.

## Interface
- WIDTH, 8: operand/result width in bits (≥1)
- CNT_W, 8: width of the beat counter (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  opcode (sampled on first beat of a result)
- in_acc  input  1  accumulate-mode beat
- in_last  input  1  final beat of an accumulate burst
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  result
- out_zero  output  1  out_data == 0
- out_count  output  CNT_W  beats folded into out_data, saturating

## Operation
- Opcodes: 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a; f(x,y) is bitwise over WIDTH.
- Accept = in_valid && in_ready; in_ready = !out_valid || out_ready in every state.
- States: IDLE, ACC.
- IDLE, accepted beat with in_acc=0 or (in_acc=1, in_last=1): result = f(in_a,in_b) with in_op; count=1; stay IDLE.
- IDLE, accepted beat with in_acc=1, in_last=0: acc=f(in_a,in_b), op latched, cnt=1, go ACC; no output.
- ACC, accepted beat: acc'=f(in_a, acc) with latched op (in_b, in_op, in_acc ignored); cnt increments, saturating at 2^CNT_W−1. If in_last=1: result=acc', count=cnt', go IDLE.
- A result loads out_data/out_count/out_zero and sets out_valid; out_valid clears on out_ready with no new result.
- Output holds stable while out_valid && !out_ready.

## Timing
- Reset: state IDLE, out_valid=0, out_data=0, out_zero=1, out_count=0, internal acc/cnt/op=0; in_ready=1 after reset deasserts.
- Latency: one cycle from accepting a result-producing beat to out_valid.
- Throughput: one beat per cycle; accept and output handshake in the same cycle replace the result with no bubble.
- Non-last ACC beats are accepted under the same in_ready rule as any other beat.
- Reset mid-burst: partial accumulation discarded; no output produced.
- Counter saturation: out_count stays at all-ones; accumulation continues correctly.
- Opcode outside range impossible (3-bit, all defined).

## Configuration
- LOGIC_UNIT_PARITY_EN defined: extra output out_parity (1 bit) = XOR-reduction of out_data, registered with out_data, reset 0.
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Package logic_unit_pkg: op enum (OP_AND..OP_PASS, 3-bit), state enum (ST_IDLE, ST_ACC).
- Sub-module logic_unit_alu: purely combinational f(x,y,op) over WIDTH; top holds FSM, accumulator, counter and output register.

## Test plan
- WIDTH=8, non-acc beats a=0xA5, b=0x3C for ops 0..7 → 0x24, 0xBD, 0x5A, 0xDB, 0x42, 0x99, 0x66, 0xA5; count=1 each; out_zero=0.
- Acc XOR burst a=0x01,0x02,0x04 (b=0x00 on first, last on third) → single output 0x07, count=3; no out_valid before the third beat.
- out_ready held 0 with result pending → in_ready=0, output stable; release with new beat same cycle → next result next cycle, no bubble.
- CNT_W=2, acc OR burst of 5 beats → out_count=3 (saturated), data correct.
- Assert rst_n low after 2 of 4 acc beats → outputs at reset values; next non-acc AND 0xFF,0x0F → 0x0F, count=1.
- With LOGIC_UNIT_PARITY_EN: result 0x07 → out_parity=1; result 0x24 → out_parity=0.
